// File: rtl/text_pixel_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : text_pixel_fetch_pkg
// Description : Shared text-mode geometry, attribute layout and sync levels.
// Revision    : 1.0 - initial release
// ============================================================================
package text_pixel_fetch_pkg;

    localparam int   c_char_w        = 8;
    localparam int   c_font_h        = 16;
    localparam int   c_cols          = 80;
    localparam int   c_rows          = 30;

    localparam int   c_fg_lsb        = 0;
    localparam int   c_bg_lsb        = 4;
    localparam int   c_blink_bit     = 7;

    localparam logic c_sync_inactive = 1'b1;

endpackage
`default_nettype wire

// File: rtl/text_pixel_fetch_sync_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : text_pixel_fetch_sync_delay_line
// Description : Fixed-depth register delay line with a synchronous reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module text_pixel_fetch_sync_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= RESET_VAL;
            end
        end else begin
            r_pipe[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/text_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module      : text_pixel_fetch
// Description : 4-clock char/attr/glyph fetch pipeline feeding the palette.
//               Optional build macro TEXT_BLINK_EN adds attribute blinking.
// Revision    : 1.0 - initial release
// ============================================================================
module text_pixel_fetch
    import text_pixel_fetch_pkg::*;
#(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int FONT_H = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        px_x,
    input  logic [9:0]        px_y,
    input  logic              active_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [ADDR_W-1:0] text_addr,
    input  logic [15:0]       text_data,
    output logic [11:0]       font_addr,
    input  logic [7:0]        font_data,
    output logic [3:0]        fg,
    output logic [3:0]        bg,
    output logic              active_out,
    output logic              hsync_out,
    output logic              vsync_out
);

    localparam int c_scan_w = $clog2(FONT_H);
    localparam int c_col_lsb = $clog2(c_char_w);

    if (COLS * ROWS > (1 << ADDR_W)) begin : g_cfg_check
        $error("text_pixel_fetch: COLS*ROWS exceeds text RAM address space");
    end

    logic [9-c_col_lsb:0] w_col;
    logic [9-c_scan_w:0]  w_row;
    logic [c_scan_w-1:0]  w_scan;
    logic [15:0]          w_addr_wide;

    assign w_col       = px_x[9:c_col_lsb];
    assign w_row       = px_y[9:c_scan_w];
    assign w_scan      = px_y[c_scan_w-1:0];
    assign w_addr_wide = 16'(w_row) * 16'(COLS) + 16'(w_col);

    // Sideband, pixel-in-glyph column and scanline travel alongside the RAM/ROM reads
    logic [2:0]          w_side_d;
    logic [2:0]          w_px_lo_d;
    logic [c_scan_w-1:0] w_scan_d;

    text_pixel_fetch_sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (4),
        .RESET_VAL ({1'b0, c_sync_inactive, c_sync_inactive})
    ) u_side_dly (
        .clk    (clk),
        .rst    (reset),
        .i_data ({active_in, hsync_in, vsync_in}),
        .o_data (w_side_d)
    );

    text_pixel_fetch_sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (4),
        .RESET_VAL (3'd0)
    ) u_pxlo_dly (
        .clk    (clk),
        .rst    (reset),
        .i_data (px_x[2:0]),
        .o_data (w_px_lo_d)
    );

    text_pixel_fetch_sync_delay_line #(
        .WIDTH     (c_scan_w),
        .DEPTH     (2),
        .RESET_VAL ('0)
    ) u_scan_dly (
        .clk    (clk),
        .rst    (reset),
        .i_data (w_scan),
        .o_data (w_scan_d)
    );

    logic [ADDR_W-1:0] r_text_addr;
    logic [11:0]       r_font_addr;
    logic [7:0]        r_attr2;
    logic [7:0]        r_attr3;
    logic [3:0]        r_fg;
    logic [3:0]        r_bg;
    logic              r_active_out;
    logic              r_hsync_out;
    logic              r_vsync_out;

    logic              w_sel;
    logic [3:0]        w_bg_attr;
    logic [3:0]        w_fg_sel;

    assign w_sel = font_data[3'd7 - w_px_lo_d];

`ifdef TEXT_BLINK_EN
    logic       r_vsync_prev;
    logic [5:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vsync_prev <= c_sync_inactive;
            r_frame_cnt  <= 6'd0;
        end else begin
            r_vsync_prev <= vsync_in;
            if (r_vsync_prev && !vsync_in) begin
                r_frame_cnt <= r_frame_cnt + 6'd1;
            end
        end
    end

    // Blinking cells show background only during the second half of each 64-frame period
    assign w_bg_attr = {1'b0, r_attr3[c_bg_lsb +: 3]};
    assign w_fg_sel  = (r_attr3[c_blink_bit] && r_frame_cnt[5]) ? w_bg_attr :
                       (w_sel ? r_attr3[c_fg_lsb +: 4] : w_bg_attr);
`else
    assign w_bg_attr = r_attr3[c_bg_lsb +: 4];
    assign w_fg_sel  = w_sel ? r_attr3[c_fg_lsb +: 4] : w_bg_attr;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_text_addr  <= '0;
            r_font_addr  <= 12'd0;
            r_attr2      <= 8'd0;
            r_attr3      <= 8'd0;
            r_fg         <= 4'd0;
            r_bg         <= 4'd0;
            r_active_out <= 1'b0;
            r_hsync_out  <= c_sync_inactive;
            r_vsync_out  <= c_sync_inactive;
        end else begin
            r_text_addr  <= w_addr_wide[ADDR_W-1:0];
            r_font_addr  <= {text_data[7:0], w_scan_d};
            r_attr2      <= text_data[15:8];
            r_attr3      <= r_attr2;
            r_fg         <= w_side_d[2] ? w_fg_sel  : 4'd0;
            r_bg         <= w_side_d[2] ? w_bg_attr : 4'd0;
            r_active_out <= w_side_d[2];
            r_hsync_out  <= w_side_d[1];
            r_vsync_out  <= w_side_d[0];
        end
    end

    assign text_addr  = r_text_addr;
    assign font_addr  = r_font_addr;
    assign fg         = r_fg;
    assign bg         = r_bg;
    assign active_out = r_active_out;
    assign hsync_out  = r_hsync_out;
    assign vsync_out  = r_vsync_out;

endmodule
`default_nettype wire

// File: doc/text_pixel_fetch.md
Name: text_pixel_fetch

Overview:
- Pipelined character/attribute fetch stage sitting directly upstream of the palette controller.
- Takes pixel coordinates and sync/blank timing from the VGA timing generator and reads the text-buffer RAM, then the font ROM.
- Drives 4-bit fg/bg colour indices into the palette controller, plus timing sideband delayed to match.
- Fixed 4-clock latency; one pixel accepted and one produced every clock.

Parameters:
COLS, 80, characters per row
ROWS, 30, character rows
FONT_H, 16, glyph height in scanlines (power of 2; log2 = 4)
ADDR_W, 12, text RAM address width (COLS*ROWS <= 2**ADDR_W)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous active-high reset
px_x  in  10  current pixel column
px_y  in  10  current pixel row
active_in  in  1  visible-region flag
hsync_in  in  1  horizontal sync, active-low
vsync_in  in  1  vertical sync, active-low
text_addr  out  ADDR_W  text RAM read address, registered
text_data  in  16  text RAM word {attr[7:0], char[7:0]}; attr = {bg[3:0], fg[3:0]}; valid 1 clk after text_addr
font_addr  out  12  font ROM address {char[7:0], scanline[3:0]}, registered
font_data  in  8  glyph row, bit 7 = leftmost pixel; valid 1 clk after font_addr
fg  out  4  visible colour index to palette
bg  out  4  background colour index to palette
active_out  out  1  active_in delayed 4 clk
hsync_out  out  1  hsync_in delayed 4 clk
vsync_out  out  1  vsync_in delayed 4 clk

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - text_addr, font_addr, fg, bg, active_out: 0.
  - hsync_out, vsync_out: 1 (inactive).
  - All pipeline sideband registers clear to the same values.
- Pipeline stages (edge numbering relative to input sample edge k):
  - S1 (edge k): col = px_x[9:3], row = px_y[9:4], scanline = px_y[3:0].
    - text_addr <= row*COLS + col, computed as (row<<6)+(row<<4)+col for COLS=80, truncated to ADDR_W.
    - Register px_x[2:0], scanline and sideband.
  - S2 (edge k+2): capture text_data.
    - font_addr <= {char, scanline}.
    - Register attr, px_x[2:0] and sideband.
  - S3 (edge k+4): sel = font_data[7 - px_x[2:0]].
    - fg <= sel ? attr_fg : attr_bg; bg <= attr_bg.
    - Register sideband outputs.
- Latency: outputs reflect inputs sampled exactly 4 edges earlier. Throughput is 1 pixel/clk with no stalls.
- Blanking: if the delayed active flag is 0 at S3, fg = bg = 0 regardless of RAM/ROM data.
- Out-of-range coordinates (px_x >= COLS*8 or px_y >= ROWS*FONT_H): address is computed and issued anyway. Output is only valid while active, so no clamping is required.
- Reset mid-frame: all stages flush in the same cycle. The first valid output appears 4 clks after reset deasserts with valid inputs.
- No handshake; the RAM and ROM must be synchronous 1-cycle-read memories.

Optional Feature:
- Macro: TEXT_BLINK_EN.
- Defined:
  - attr[7] is a blink flag and bg uses attr[6:4] zero-extended to 4 bits.
  - A 6-bit frame counter increments on each vsync_in falling edge; reset clears it to 0.
  - blink_phase = counter[5], i.e. toggles every 32 frames.
  - When attr[7]=1 and blink_phase=1, fg output = bg (glyph hidden).
- Undefined: attr[7:4] is a full 4-bit bg, there is no counter, and blink logic is absent.

Decomposition:
- Shared package/header (text_mode_defs):
  - CHAR_W=8, FONT_H=16, COLS, ROWS.
  - Attribute field positions (FG_LSB=0, BG_LSB=4, BLINK_BIT=7).
  - SYNC_INACTIVE=1.
- One natural sub-module: sync_delay_line (parameterised width and depth, synchronous reset to a parameterised value). Used for the active/hsync/vsync sideband.

Test Plan:
- Reset held 3 clks with hsync_in=0 -> hsync_out=vsync_out=1, fg=bg=0, text_addr=0 throughout and 1 clk after release.
- px_x=17, px_y=35 -> text_addr = 2*80+2 = 162 one edge later. With text_data=0x1E41 -> font_addr = {0x41, 3} = 0x413.
- Font row 0b00100000, attr 0x1E, px_x[2:0]=2 -> fg=0xE, bg=0x1 exactly 4 edges after input. At px_x[2:0]=3 -> fg=0x1.
- active_in=0 with any data -> fg=bg=0. active_in, hsync_in and vsync_in pulses reappear at outputs delayed exactly 4 clks.
- Reset asserted mid-line for 1 clk -> all outputs at reset values on the next edge. Valid pixels resume 4 clks after release.
- TEXT_BLINK_EN defined, attr 0x9E, glyph bit set -> fg=0xE for frames 0-31 and fg=0x1 for frames 32-63.
